// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer
//   Positioned, animated sprite renderer for the VGA pixel path. It decides
//   whether the beam position falls inside one movable sprite and issues the
//   sprite-sheet ROM address. The ROM index comes back one cycle later, and the
//   block then produces a registered palette index plus an opaque-hit flag.
//   Animation frames advance on vsync strobes, in loop or one-shot mode.
//
// Ports
//   vga_clk, reset_n      pixel clock, synchronous active-low reset
//   DrawX, DrawY, blank   beam position and active-video flag
//   vsync_pulse           frame strobe; latches position/flip, steps animation
//   pos_x, pos_y, flip_h  sprite placement (shadowed at vsync)
//   anim_en, anim_loop    animation enable and loop/one-shot select
//   rom_addr, rom_q       synchronous ROM interface (1-cycle read latency)
//   pix_valid, pix_index  registered overlay result, 2 cycles after DrawX/DrawY
//   frame_idx, anim_done  animation status
//
// state | meaning
// IDLE  | animation stopped, frame 0
// RUN   | stepping frames every FRAME_HOLD vsync strobes
// DONE  | one-shot finished, last frame held
module sprite_anim_renderer #(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 40,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H),
  localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               vsync_pulse,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip_h,
  input  logic               anim_en,
  input  logic               anim_loop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic               pix_valid,
  output logic [IDX_W-1:0]   pix_index,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               anim_done
);

  localparam int FW    = SPR_W << SCALE_LOG2;
  localparam int FH    = SPR_H << SCALE_LOG2;
  localparam int CNT_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [9:0]         r_sx, r_sy;
  logic               r_flip;
  logic               r_s1_hit, r_s2_hit;
  logic [IDX_W-1:0]   r_rom_q;

  logic               w_hit;
  logic [9:0]         w_dx, w_dy, w_lx, w_ly, w_lx_f;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_pix_valid_nxt;

  // 11-bit compares so a sprite hanging past the right/bottom edge clips
  // instead of wrapping back to column/row 0.
  assign w_hit = ({1'b0, DrawX} >= {1'b0, r_sx}) &&
                 ({1'b0, DrawX} <  ({1'b0, r_sx} + 11'(FW))) &&
                 ({1'b0, DrawY} >= {1'b0, r_sy}) &&
                 ({1'b0, DrawY} <  ({1'b0, r_sy} + 11'(FH)));

  // Only meaningful when w_hit is set; the address is forced to 0 otherwise.
  assign w_dx   = DrawX - r_sx;
  assign w_dy   = DrawY - r_sy;
  assign w_lx   = w_dx >> SCALE_LOG2;
  assign w_ly   = w_dy >> SCALE_LOG2;
  assign w_lx_f = r_flip ? (10'(SPR_W - 1) - w_lx) : w_lx;

  assign w_addr = ADDR_W'(r_frame) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(w_ly) * ADDR_W'(SPR_W)
                + ADDR_W'(w_lx_f);

  assign w_pix_valid_nxt = r_s2_hit && (r_rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_sx      <= '0;
      r_sy      <= '0;
      r_flip    <= 1'b0;
      rom_addr  <= '0;
      r_s1_hit  <= 1'b0;
      r_s2_hit  <= 1'b0;
      r_rom_q   <= '0;
      pix_valid <= 1'b0;
      pix_index <= '0;
    end else begin
      // Rendering only sees placement changes at frame boundaries (no tearing).
      if (vsync_pulse) begin
        r_sx   <= pos_x;
        r_sy   <= pos_y;
        r_flip <= flip_h;
      end
      rom_addr  <= w_hit ? w_addr : '0;
      r_s1_hit  <= w_hit & blank;
      r_s2_hit  <= r_s1_hit;
      r_rom_q   <= rom_q;
      pix_valid <= w_pix_valid_nxt;
      pix_index <= w_pix_valid_nxt ? r_rom_q : '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_frame_nxt = '0;
        w_cnt_nxt   = '0;
        if (anim_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Disable beats a coincident vsync: the counter is not stepped.
        if (!anim_en) begin
          w_state_nxt = S_IDLE;
          w_frame_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (vsync_pulse) begin
          if (32'(r_cnt) < FRAME_HOLD - 1) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_cnt_nxt = '0;
            if (32'(r_frame) < NUM_FRAMES - 1) w_frame_nxt = r_frame + 1'b1;
            else if (anim_loop)                w_frame_nxt = '0;
            else                               w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!anim_en) begin
          w_state_nxt = S_IDLE;
          w_frame_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_frame_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign frame_idx = r_frame;
  assign anim_done = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// tb_sprite_anim_renderer
//   Directed bench for sprite_anim_renderer. dut0 is unscaled, dut1 uses
//   SCALE_LOG2=1; both use FRAME_HOLD=2 and share every input.
module tb_sprite_anim_renderer;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, vsync_pulse, flip_h, anim_en, anim_loop;
  logic [3:0] rom_q;

  logic [11:0] addr0, addr1;
  logic        valid0, valid1, done0, done1;
  logic [3:0]  index0, index1;
  logic [1:0]  frame0, frame1;

  int n_cmp  = 0;
  int n_fail = 0;

  sprite_anim_renderer #(.FRAME_HOLD(2), .SCALE_LOG2(0)) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vsync_pulse(vsync_pulse), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en), .anim_loop(anim_loop),
    .rom_addr(addr0), .rom_q(rom_q), .pix_valid(valid0), .pix_index(index0),
    .frame_idx(frame0), .anim_done(done0));

  sprite_anim_renderer #(.FRAME_HOLD(2), .SCALE_LOG2(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vsync_pulse(vsync_pulse), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en), .anim_loop(anim_loop),
    .rom_addr(addr1), .rom_q(rom_q), .pix_valid(valid1), .pix_index(index1),
    .frame_idx(frame1), .anim_done(done1));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        sel;
    logic [9:0]  px, py;
    logic        flip;
    logic [9:0]  dx, dy;
    logic        blk;
    logic [3:0]  q;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [3:0]  e_index;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic sel, input int px, input int py,
                              input logic flip, input int dx, input int dy,
                              input logic blk, input int q, input int e_addr,
                              input logic e_valid, input int e_index);
    vec_t v;
    v.sel = sel; v.px = 10'(px); v.py = 10'(py); v.flip = flip;
    v.dx = 10'(dx); v.dy = 10'(dy); v.blk = blk; v.q = 4'(q);
    v.e_addr = 12'(e_addr); v.e_valid = e_valid; v.e_index = 4'(e_index);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic strobe();
    @(negedge vga_clk) vsync_pulse = 1'b1;
    @(negedge vga_clk) vsync_pulse = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge vga_clk);
    pos_x = v.px; pos_y = v.py; flip_h = v.flip; vsync_pulse = 1'b1;
    @(negedge vga_clk);
    vsync_pulse = 1'b0;
    DrawX = v.dx; DrawY = v.dy; blank = v.blk; rom_q = v.q;
    @(posedge vga_clk); #1;
    chk({tag, " rom_addr"}, v.sel ? addr1 : addr0, v.e_addr);
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    chk({tag, " pix_valid"}, v.sel ? valid1 : valid0, v.e_valid);
    chk({tag, " pix_index"}, v.sel ? index1 : index0, v.e_index);
  endtask

  initial begin
    // sel, pos_x, pos_y, flip, DrawX, DrawY, blank, rom_q, addr, valid, index
    vt.push_back(mk(0, 100, 50, 0, 100, 50, 1, 3,   0, 1, 3));
    vt.push_back(mk(0, 100, 50, 0, 120, 50, 1, 3,   0, 0, 0));
    vt.push_back(mk(0, 100, 50, 0, 105, 52, 1, 3,  45, 1, 3));
    vt.push_back(mk(0, 100, 50, 0, 119, 89, 1, 5, 799, 1, 5));
    vt.push_back(mk(0, 100, 50, 0,  99, 50, 1, 3,   0, 0, 0));
    vt.push_back(mk(0, 100, 50, 0, 100, 90, 1, 3,   0, 0, 0));
    vt.push_back(mk(0, 100, 50, 0, 100, 49, 1, 3,   0, 0, 0));
    vt.push_back(mk(0, 100, 50, 0, 105, 52, 1, 0,  45, 0, 0));
    vt.push_back(mk(0, 100, 50, 0, 105, 52, 0, 3,  45, 0, 0));
    vt.push_back(mk(0, 100, 50, 1, 105, 52, 1, 3,  54, 1, 3));
    vt.push_back(mk(0, 100, 50, 1, 100, 50, 1, 7,  19, 1, 7));
    vt.push_back(mk(0, 100, 50, 1, 119, 51, 1, 3,  20, 1, 3));
    vt.push_back(mk(0, 630, 50, 0, 630, 50, 1, 3,   0, 1, 3));
    vt.push_back(mk(0, 630, 50, 0, 639, 50, 1, 3,   9, 1, 3));
    vt.push_back(mk(0, 630, 50, 0,   0, 50, 1, 3,   0, 0, 0));
    vt.push_back(mk(0, 630, 50, 0,   9, 50, 1, 3,   0, 0, 0));
    vt.push_back(mk(1, 100, 50, 0, 103, 55, 1, 3,  41, 1, 3));
    vt.push_back(mk(1, 100, 50, 0, 139, 129, 1, 3, 799, 1, 3));
    vt.push_back(mk(1, 100, 50, 0, 140, 50, 1, 3,   0, 0, 0));
    vt.push_back(mk(1, 100, 50, 0, 100, 130, 1, 3,  0, 0, 0));
    vt.push_back(mk(1, 100, 50, 1, 103, 55, 1, 3,  58, 1, 3));
    vt.push_back(mk(1, 630, 50, 0,   0, 50, 1, 3,   0, 0, 0));

    // Reset held with inputs that would otherwise produce activity.
    reset_n = 1'b0; pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
    vsync_pulse = 1'b1; anim_en = 1'b1; anim_loop = 1'b1;
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; rom_q = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge vga_clk); #1;
      chk("rst rom_addr", addr0, 0);
      chk("rst pix_valid", valid0, 0);
      chk("rst pix_index", index0, 0);
      chk("rst frame_idx", frame0, 0);
      chk("rst anim_done", done0, 0);
    end
    @(negedge vga_clk);
    reset_n = 1'b1; vsync_pulse = 1'b0; anim_en = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply_vec(vt[i], i);

    // Latency: a single hit cycle at edge N shows up only at edge N+2.
    @(negedge vga_clk);
    pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0; vsync_pulse = 1'b1;
    DrawX = 10'd120; DrawY = 10'd50; blank = 1'b1; rom_q = 4'd3;
    @(negedge vga_clk) vsync_pulse = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk) DrawX = 10'd100;
    @(negedge vga_clk) DrawX = 10'd120;
    #6 chk("lat N+1 pix_valid", valid0, 0);
    @(posedge vga_clk); #1;
    chk("lat N+2 pix_valid", valid0, 1);
    chk("lat N+2 pix_index", index0, 3);
    @(posedge vga_clk); #1;
    chk("lat N+3 pix_valid", valid0, 0);

    // Loop animation.
    @(negedge vga_clk) begin anim_loop = 1'b1; anim_en = 1'b1; end
    @(negedge vga_clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("loop frame before strobe %0d", k + 1), frame0, k / 2);
      strobe();
    end
    chk("loop wrap frame", frame0, 0);
    chk("loop anim_done", done0, 0);
    strobe();
    strobe();
    chk("loop frame after 10", frame0, 1);
    @(negedge vga_clk) anim_en = 1'b0;
    @(negedge vga_clk);
    chk("loop disable frame", frame0, 0);

    // vsync coinciding with disable: IDLE wins.
    @(negedge vga_clk) anim_en = 1'b1;
    @(negedge vga_clk);
    strobe();
    @(negedge vga_clk) begin anim_en = 1'b0; vsync_pulse = 1'b1; end
    @(negedge vga_clk) vsync_pulse = 1'b0;
    chk("coincide frame", frame0, 0);
    @(negedge vga_clk) anim_en = 1'b1;
    @(negedge vga_clk);
    strobe();
    chk("coincide cnt cleared", frame0, 0);
    @(negedge vga_clk) anim_en = 1'b0;
    @(negedge vga_clk);

    // One-shot.
    @(negedge vga_clk) begin anim_loop = 1'b0; anim_en = 1'b1; end
    @(negedge vga_clk);
    for (int k = 0; k < 7; k++) strobe();
    chk("oneshot frame at 7", frame0, 3);
    chk("oneshot done at 7", done0, 0);
    strobe();
    chk("oneshot frame at 8", frame0, 3);
    chk("oneshot done at 8", done0, 1);
    @(negedge vga_clk) anim_loop = 1'b1;
    strobe();
    chk("done hold frame", frame0, 3);
    chk("done hold flag", done0, 1);
    @(negedge vga_clk) begin anim_en = 1'b0; anim_loop = 1'b0; end
    @(negedge vga_clk);
    chk("done exit frame", frame0, 0);
    chk("done exit flag", done0, 0);

    // Reset mid-run with a live pixel in the pipeline.
    @(negedge vga_clk) begin
      anim_en = 1'b1; DrawX = 10'd105; DrawY = 10'd52; blank = 1'b1; rom_q = 4'd3;
    end
    @(negedge vga_clk);
    strobe(); strobe(); strobe();
    chk("midrun frame", frame0, 1);
    chk("midrun pix_valid", valid0, 1);
    chk("midrun rom_addr", addr0, 20 * 40 + 45);
    @(negedge vga_clk) reset_n = 1'b0;
    @(negedge vga_clk);
    chk("midrst frame", frame0, 0);
    chk("midrst pix_valid", valid0, 0);
    chk("midrst pix_index", index0, 0);
    chk("midrst rom_addr", addr0, 0);
    chk("midrst anim_done", done0, 0);
    reset_n = 1'b1;
    @(negedge vga_clk);
    chk("post rst frame", frame0, 0);
    chk("post rst shadow miss", addr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Positioned, animated sprite renderer for the VGA pixel path.
- Decides whether the current beam position is covered by one movable sprite and computes the ROM address into a multi-frame sprite sheet. It supports horizontal flip and integer power-of-two scaling.
- Emits a registered palette index plus an opaque-hit flag, which the downstream compositor uses to overlay this sprite on the background.
- Advances animation frames on vertical-sync strobes, in loop or one-shot mode.

Parameters:
- SPR_W, 20, sprite frame width in source pixels
- SPR_H, 40, sprite frame height in source pixels
- NUM_FRAMES, 4, frames stacked consecutively in ROM, frame-major, row-major within each frame
- FRAME_HOLD, 8, vsync strobes each frame is displayed (>=1)
- SCALE_LOG2, 0, on-screen magnification 2^SCALE_LOG2 in each axis
- IDX_W, 4, palette index width
- TRANSP_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- reset_n  in  1  synchronous, active-low reset
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- blank  in  1  1 = active video region
- vsync_pulse  in  1  one-cycle strobe at start of vertical blank
- pos_x  in  10  sprite top-left column (screen pixels)
- pos_y  in  10  sprite top-left row
- flip_h  in  1  1 = mirror horizontally
- anim_en  in  1  1 = animate
- anim_loop  in  1  1 = loop, 0 = one-shot
- rom_addr  out  ADDR_W  registered address to external synchronous ROM (1-cycle read latency)
- rom_q  in  IDX_W  ROM data for the address presented the previous cycle
- pix_valid  out  1  registered: sprite covers pixel, index opaque, video active
- pix_index  out  IDX_W  registered palette index (0 when pix_valid=0)
- frame_idx  out  $clog2(NUM_FRAMES) or 1  current animation frame
- anim_done  out  1  one-shot finished, held

Behaviour:
- Reset (reset_n=0 at posedge): rom_addr=0, pix_valid=0, pix_index=0, frame_idx=0, anim_done=0, hold counter=0, shadow registers=0, pipeline valid bits=0, FSM=IDLE. A reset mid-animation aborts to this state in the same edge.
- Shadow registers: pos_x, pos_y and flip_h are captured only on cycles with vsync_pulse=1. All rendering uses the shadow copies, so the sprite never tears mid-frame.
- Footprint: FW = SPR_W<<SCALE_LOG2 and FH = SPR_H<<SCALE_LOG2.
- Hit test: hit = (DrawX>=sx) && (DrawX<sx+FW) && (DrawY>=sy) && (DrawY<sy+FH).
  - Compare in 11 bits so sx+FW beyond 639 does not wrap; the sprite is clipped at the right and bottom edges.
- Local coordinates:
  - lx = (DrawX-sx)>>SCALE_LOG2 and ly = (DrawY-sy)>>SCALE_LOG2.
  - If flip is set, lx' = SPR_W-1-lx; otherwise lx' = lx.
- Stage 1 (posedge N):
  - rom_addr <= hit ? frame_idx*SPR_W*SPR_H + ly*SPR_W + lx' : 0.
  - Register s1_hit = hit & blank.
- Stage 2 (posedge N+1): rom_q is valid for the stage-1 address; register s2_hit = s1_hit and capture rom_q.
- Stage 3 (posedge N+2):
  - pix_valid <= s2_hit && (rom_q_reg != TRANSP_IDX).
  - pix_index <= pix_valid_next ? rom_q_reg : 0.
  - Fixed latency: DrawX/DrawY sampled at edge N produce output at edge N+2 (3 registers, 2 cycles after address issue). Identical for every pixel.
- Animation FSM, evaluated each posedge:
  - IDLE:
    - frame_idx=0, counter=0, anim_done=0.
    - If anim_en=1, go to RUN.
  - RUN:
    - If anim_en=0: go to IDLE; frame_idx and counter go to 0 at that edge.
    - Otherwise, on each vsync_pulse:
      - If counter<FRAME_HOLD-1: counter++.
      - Else: counter=0. If frame_idx<NUM_FRAMES-1, frame_idx++.
      - Else, in loop mode: frame_idx=0.
      - Else, in one-shot mode: go to DONE, frame_idx stays at NUM_FRAMES-1, anim_done=1.
  - DONE:
    - Holds the last frame with anim_done=1.
    - If anim_en=0, go to IDLE (anim_done cleared at the same edge).
    - If anim_loop rises while in DONE, there is no effect.
  - anim_loop is sampled at the wrap decision only.
  - A vsync_pulse coinciding with anim_en falling: the IDLE transition wins and the counter is not advanced.
  - frame_idx changes only at vsync or IDLE entry. The frame used for addressing is therefore stable within a visible frame.
- NUM_FRAMES=1: the frame never advances. One-shot mode reaches DONE after FRAME_HOLD strobes.

Test Plan:
- Reset and idle: reset_n=0 for 2 clocks, then sprite at (100,50) with the ROM returning index 3 everywhere. Require:
  - All outputs are 0 during reset.
  - DrawX=100, DrawY=50 sampled at edge N gives pix_valid=1, pix_index=3 at edge N+2.
  - DrawX=120 gives pix_valid=0.
- Addressing and flip: with frame 0 and pixel (105,52), require rom_addr=2*20+5=45. With flip_h latched at vsync, the same pixel requires rom_addr=40+14=54.
- Transparency, clipping and blank:
  - ROM index 0 gives pix_valid=0 and pix_index=0.
  - Sprite at pos_x=630 shows hits for DrawX 630..639 only, with no wrap hit at DrawX 0..9.
  - blank=0 forces pix_valid=0.
- Scaling with SCALE_LOG2=1: footprint is 40x80. Pixel (pos+3, pos+5) requires rom_addr = 2*20+1 = 41.
- Loop animation (FRAME_HOLD=2, NUM_FRAMES=4, anim_en=1, anim_loop=1): after 8 vsync strobes the frame sequence is 0,0,1,1,2,2,3,3 and returns to 0. Dropping anim_en forces frame_idx to 0 on the next edge.
- One-shot: anim_loop=0 gives anim_done=1 after the 8th strobe with frame_idx held at 3. Asserting reset_n=0 mid-run returns all state to 0 in one edge.
